// File: rtl/mult_div_unit_if.sv
// Request/result bundle between a pipeline's execute stage and the HI/LO multiply-divide unit.
// The master drives the request and register-file data; the slave returns HI/LO and status.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rdat1;
  logic [31:0] rdat2;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] wdat;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (
    output start, op, rdat1, rdat2, hi_write, lo_write, wdat,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, rdat1, rdat2, hi_write, lo_write, wdat,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit owning the HI and LO registers.
// Signed operations work on magnitudes and apply sign correction when HI/LO are written.
module mult_div_unit (
  input  logic           clk,
  input  logic           rst,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  count_reg;
  logic [31:0] opnd_reg;
  logic [63:0] p_reg;
  logic        op_div_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic        dz_reg;
  logic [31:0] hi_reg, lo_reg;
  logic        busy_reg, done_reg, div_zero_reg;

  logic        req_div, req_signed, req_dz;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_diff;
  logic [63:0] p_next_mul, p_next_div, p_next;
  logic [31:0] res_hi, res_lo;
  logic [63:0] prod_neg;

  assign req_div    = bus.op[1];
  assign req_signed = ~bus.op[0];
  assign req_dz     = req_div && (bus.rdat2 == 32'd0);
  assign a_abs      = (req_signed && bus.rdat1[31]) ? -bus.rdat1 : bus.rdat1;
  assign b_abs      = (req_signed && bus.rdat2[31]) ? -bus.rdat2 : bus.rdat2;

  // Multiply: p holds {partial product, remaining multiplier bits}; add then shift right.
  assign mul_sum    = {1'b0, p_reg[63:32]} + (p_reg[0] ? {1'b0, opnd_reg} : 33'd0);
  assign p_next_mul = {mul_sum, p_reg[31:1]};

  // Divide: p holds {partial remainder, dividend bits shifting into quotient bits}.
  assign div_shift  = {p_reg[63:32], p_reg[31]};
  assign div_diff   = div_shift - {1'b0, opnd_reg};
  assign p_next_div = div_diff[32] ? {div_shift[31:0], p_reg[30:0], 1'b0}
                                   : {div_diff[31:0],  p_reg[30:0], 1'b1};

  assign p_next     = op_div_reg ? p_next_div : p_next_mul;
  assign prod_neg   = -p_next;

  always_comb begin
    res_hi = p_next[63:32];
    res_lo = p_next[31:0];
    if (op_div_reg) begin
      res_lo = neg_q_reg ? -p_next[31:0]  : p_next[31:0];
      res_hi = neg_r_reg ? -p_next[63:32] : p_next[63:32];
    end else if (neg_q_reg) begin
      res_hi = prod_neg[63:32];
      res_lo = prod_neg[31:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = req_dz ? DONE : CALC;
      CALC:    if (count_reg == 5'd31) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= 5'd0;
      opnd_reg     <= 32'd0;
      p_reg        <= 64'd0;
      op_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      dz_reg       <= 1'b0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      busy_reg     <= (state_next != IDLE);
      done_reg     <= (state_reg == DONE);
      div_zero_reg <= (state_reg == DONE) && dz_reg;
      case (state_reg)
        IDLE: begin
          if (bus.hi_write) hi_reg <= bus.wdat;
          if (bus.lo_write) lo_reg <= bus.wdat;
          if (bus.start) begin
            op_div_reg <= req_div;
            opnd_reg   <= req_div ? b_abs : a_abs;
            p_reg      <= {32'd0, (req_div ? a_abs : b_abs)};
            neg_q_reg  <= req_signed && (bus.rdat1[31] ^ bus.rdat2[31]);
            neg_r_reg  <= req_signed && bus.rdat1[31];
            dz_reg     <= req_dz;
            count_reg  <= 5'd0;
          end
        end
        CALC: begin
          p_reg     <= p_next;
          count_reg <= count_reg + 5'd1;
          if (count_reg == 5'd31) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.div_zero = div_zero_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: products, quotients, latency, divide-by-zero,
// busy-time request filtering and reset behaviour.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_div_unit_if bus();

  mult_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble operands after acceptance, and check result and latency.
  // Latency counts clock edges from the accepting edge to the edge raising done.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit wr, input logic [31:0] eh,
                        input logic [31:0] el, input bit edz, input int elat);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rdat1 = a;
    bus.rdat2 = b;
    if (wr) begin
      bus.hi_write = 1'b1;
      bus.lo_write = 1'b1;
      bus.wdat     = 32'h5555AAAA;
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.hi_write = 1'b0;
    bus.lo_write = 1'b0;
    bus.rdat1    = $urandom;
    bus.rdat2    = $urandom;
    cyc = 1;
    check({tag, ".busy"}, bus.busy, 1);
    while (!bus.done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, cyc - 1, elat);
    check({tag, ".hi"}, bus.hi, eh);
    check({tag, ".lo"}, bus.lo, el);
    check({tag, ".div_zero"}, bus.div_zero, edz);
    $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b lat=%0d",
             tag, op, a, b, bus.hi, bus.lo, bus.div_zero, cyc - 1);
    @(negedge clk);
    check({tag, ".done_pulse"}, bus.done, 0);
    check({tag, ".dz_clear"}, bus.div_zero, 0);
  endtask

  initial begin
    int ndone;
    logic [31:0] cap_hi, cap_lo;

    // Reset held with start and writes asserted: reset must win.
    rst = 1'b1;
    bus.start = 1'b1; bus.op = 2'b01; bus.rdat1 = 32'd9; bus.rdat2 = 32'd9;
    bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.wdat = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    check("rst.hi", bus.hi, 0);
    check("rst.lo", bus.lo, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    check("rst.div_zero", bus.div_zero, 0);
    $display("txn reset hi=%h lo=%h busy=%0b", bus.hi, bus.lo, bus.busy);
    bus.start = 1'b0; bus.hi_write = 1'b0; bus.lo_write = 1'b0;
    rst = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 32'h00000001, 0, 33);
    run_op("mult_neg3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 33);
    run_op("divu_100_7_wr", 2'b11, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, 33);
    run_op("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33);
    run_op("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 32'h0, 32'h80000000, 0, 33);
    run_op("mult_min_min", 2'b00, 32'h80000000, 32'h80000000, 0, 32'h40000000, 32'h0, 0, 33);
    run_op("mult_5_m4", 2'b00, 32'd5, 32'hFFFFFFFC, 0, 32'hFFFFFFFF, 32'hFFFFFFEC, 0, 33);
    run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 0, 32'd1, 32'hFFFFFFFD, 0, 33);
    run_op("divu_max_1", 2'b11, 32'hFFFFFFFF, 32'd1, 0, 32'd0, 32'hFFFFFFFF, 0, 33);
    run_op("divu_3_10", 2'b11, 32'd3, 32'd10, 0, 32'd3, 32'd0, 0, 33);

    // Direct HI/LO writes in IDLE, then a divide by zero leaves them untouched.
    @(negedge clk); bus.hi_write = 1'b1; bus.wdat = 32'h0000ABCD;
    @(negedge clk); bus.hi_write = 1'b0; bus.lo_write = 1'b1; bus.wdat = 32'h00001234;
    @(negedge clk); bus.lo_write = 1'b0;
    check("mthi", bus.hi, 32'h0000ABCD);
    check("mtlo", bus.lo, 32'h00001234);
    $display("txn mthi/mtlo hi=%h lo=%h", bus.hi, bus.lo);
    run_op("div_by_zero", 2'b10, 32'd5, 32'd0, 0, 32'h0000ABCD, 32'h00001234, 1, 1);

    // Reset during the 10th CALC cycle aborts without a done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.rdat1 = 32'h1234; bus.rdat2 = 32'h10;
    ndone = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) ndone++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", bus.busy, 0);
    check("abort.hi", bus.hi, 0);
    check("abort.lo", bus.lo, 0);
    check("abort.done", bus.done, 0);
    repeat (40) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort.no_done", ndone, 0);
    $display("txn abort hi=%h lo=%h busy=%0b dones=%0d", bus.hi, bus.lo, bus.busy, ndone);
    run_op("multu_after_abort", 2'b01, 32'd6, 32'd7, 0, 32'd0, 32'd42, 0, 33);

    // start and hi_write/lo_write held for the whole busy period: one result, writes ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.rdat1 = 32'd3; bus.rdat2 = 32'd5;
    ndone = 0; cap_hi = 32'hX; cap_lo = 32'hX;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (i <= 32) begin
        bus.start    = 1'b1;
        bus.op       = 2'(i);
        bus.rdat1    = $urandom;
        bus.rdat2    = $urandom;
        bus.hi_write = (i > 1);
        bus.lo_write = (i > 1);
        bus.wdat     = 32'hDEADBEEF;
      end else begin
        bus.start = 1'b0; bus.hi_write = 1'b0; bus.lo_write = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        cap_hi = bus.hi;
        cap_lo = bus.lo;
      end
    end
    check("hold.dones", ndone, 1);
    check("hold.hi", cap_hi, 32'd0);
    check("hold.lo", cap_lo, 32'd15);
    $display("txn hold_start dones=%0d hi=%h lo=%h", ndone, cap_hi, cap_lo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: start  input  1  request; accepted only in IDLE.
REQ-004 SHALL have ports: op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-005 SHALL have ports: rdat1  input  32  operand A (multiplicand/dividend), from register file Read Data 1.
REQ-006 SHALL have ports: rdat2  input  32  operand B (multiplier/divisor), from register file Read Data 2.
REQ-007 SHALL have ports: hi_write  input  1  MTHI; load wdat into HI.
REQ-008 SHALL have ports: lo_write  input  1  MTLO; load wdat into LO.
REQ-009 SHALL have ports: wdat  input  32  data for hi_write/lo_write.
REQ-010 SHALL have ports: hi  output  32  HI register (MFHI source).
REQ-011 SHALL have ports: lo  output  32  LO register (MFLO source).
REQ-012 SHALL have ports: busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have ports: done  output  1  one-cycle pulse, result valid.
REQ-014 SHALL have ports: div_zero  output  1  high with done when a DIV/DIVU divisor was 0.

Function
REQ-015 SHALL implement states IDLE, CALC, DONE; registered outputs only.
REQ-016 IDLE + start: latch op, |rdat1|, |rdat2| (signed ops) or raw operands (unsigned ops), result sign flags, iteration count 0; go CALC.
REQ-017 IDLE + start + DIV/DIVU with rdat2 == 0: go directly to DONE, HI/LO unchanged, div_zero = 1 during DONE.
REQ-018 CALC: one iteration per cycle, 32 iterations (count 0..31); multiply = shift-add over 64-bit product; divide = restoring, 1 quotient bit per cycle.
REQ-019 CALC with count == 31: go DONE; on that same edge, write HI/LO with sign correction applied.
REQ-020 DONE: done = 1 for exactly one cycle; next state IDLE unconditionally.
REQ-021 Latency: start sampled at edge N -> done high in cycle after edge N+33 (div-by-zero: after edge N+1); next start accepted at edge N+34.
REQ-022 MULT/MULTU: {HI,LO} = 64-bit product, two's complement for MULT.
REQ-023 DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with dividend's sign.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0; no exception flag.
REQ-025 start while busy (CALC or DONE) SHALL be ignored; no queuing.
REQ-026 hi_write/lo_write SHALL take effect only in IDLE; ignored while busy.
REQ-027 Simultaneous start and hi_write/lo_write in IDLE: write occurs and start is accepted; the final result overwrites HI/LO.
REQ-028 Operand inputs may change after acceptance without affecting the result.
REQ-029 div_zero SHALL be 0 except during the DONE cycle of a zero-divisor division.

Reset
REQ-030 rst high at an edge: state = IDLE, HI = LO = 0, busy = done = div_zero = 0, counter and operand registers cleared.
REQ-031 rst SHALL override start, hi_write, and lo_write in the same cycle.
REQ-032 rst mid-CALC: abort, no done pulse, HI/LO = 0.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done 33 cycles after accept; HI = 0xFFFFFFFE, LO = 0x00000001.
REQ-034 MULT 0xFFFFFFFD (-3) x 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; separately DIVU 100 / 7 -> LO = 14, HI = 2.
REQ-035 DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
REQ-036 lo_write 0x1234 then DIV 5 / 0 -> done and div_zero high 1 cycle after accept; LO = 0x1234, HI unchanged.
REQ-037 start re-asserted every cycle during a MULT -> exactly one done; hi_write during CALC -> HI = product, not wdat.
REQ-038 rst at 10th CALC cycle -> next cycle busy = 0, HI = LO = 0, no done; new start then completes normally.
